// File: rtl/fft8_input_reorder_if.sv
// Sample-in / frame-out handshake bundle for fft8_input_reorder.
// in_sof and sof_err exist only when FFT8_REORDER_SOF_EN is defined.
interface fft8_input_reorder_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8;
`ifdef FFT8_REORDER_SOF_EN
  logic              in_sof;
  logic              sof_err;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef FFT8_REORDER_SOF_EN
    input  in_sof,
    output sof_err,
`endif
    output in_ready, out_valid, out1, out2, out3, out4, out5, out6, out7, out8
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef FFT8_REORDER_SOF_EN
    output in_sof,
    input  sof_err,
`endif
    input  in_ready, out_valid, out1, out2, out3, out4, out5, out6, out7, out8
  );
endinterface

// File: rtl/fft8_input_reorder.sv
// 8-point FFT input stage: serial samples into a ping-pong store, frames out in bit-reversed order.
// Optional FFT8_REORDER_SOF_EN adds in_sof resync and a sticky sof_err flag.
module fft8_input_reorder #(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft8_input_reorder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_st_e;

  bank_st_e          st_q [2];
  bank_st_e          st_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [2:0]        wr_ptr_q, wr_ptr_d;
  logic [2:0]        wr_idx;
  logic              wr_en, rd_en, wrap;
  logic [DATA_W-1:0] mem_q [2][8];
`ifdef FFT8_REORDER_SOF_EN
  logic              sof_err_q, sof_err_d;
`endif

  // Handshake outputs depend only on registered bank state (and reset).
  assign bus.in_ready  = rst_n && (st_q[wr_bank_q] != ST_FULL);
  assign bus.out_valid = (st_q[rd_bank_q] == ST_FULL);

  assign wr_en = bus.in_valid && bus.in_ready;
  assign rd_en = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_idx = wr_ptr_q;
`ifdef FFT8_REORDER_SOF_EN
    if (bus.in_sof) wr_idx = 3'd0;
`endif
  end

  assign wrap = wr_en && (wr_idx == 3'd7);

  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
`ifdef FFT8_REORDER_SOF_EN
    sof_err_d = sof_err_q;
`endif
    for (int b = 0; b < 2; b++) begin
      // A read and a write never target the same bank in one cycle.
      if (rd_en && (rd_bank_q == 1'(b))) begin
        st_d[b] = ST_EMPTY;
      end else if (wr_en && (wr_bank_q == 1'(b))) begin
        st_d[b] = wrap ? ST_FULL : ST_FILLING;
      end
    end
    if (wr_en) begin
      wr_ptr_d = wr_idx + 3'd1;
      if (wrap) wr_bank_d = ~wr_bank_q;
`ifdef FFT8_REORDER_SOF_EN
      if (bus.in_sof && (wr_ptr_q != 3'd0)) sof_err_d = 1'b1;
`endif
    end
    if (rd_en) rd_bank_d = ~rd_bank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= ST_EMPTY;
      st_q[1]   <= ST_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= 3'd0;
`ifdef FFT8_REORDER_SOF_EN
      sof_err_q <= 1'b0;
`endif
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
`ifdef FFT8_REORDER_SOF_EN
      sof_err_q <= sof_err_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          mem_q[b][k] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_q[wr_bank_q][wr_idx] <= bus.in_data;
    end
  end

  // Bit-reversed presentation pairs butterfly partners on adjacent outputs.
  assign bus.out1 = mem_q[rd_bank_q][0];
  assign bus.out2 = mem_q[rd_bank_q][4];
  assign bus.out3 = mem_q[rd_bank_q][2];
  assign bus.out4 = mem_q[rd_bank_q][6];
  assign bus.out5 = mem_q[rd_bank_q][1];
  assign bus.out6 = mem_q[rd_bank_q][5];
  assign bus.out7 = mem_q[rd_bank_q][3];
  assign bus.out8 = mem_q[rd_bank_q][7];

`ifdef FFT8_REORDER_SOF_EN
  assign bus.sof_err = sof_err_q;
`endif

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Directed bench for fft8_input_reorder: vector table, backpressure, reset, random scoreboard.
module tb_fft8_input_reorder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fft8_input_reorder_if #(.DATA_W(8)) bus ();

  fft8_input_reorder #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din  [8];
    logic [7:0] dout [8];
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] sb [$];
`ifdef FFT8_REORDER_SOF_EN
  logic       sof_drv;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.out1, bus.out2, bus.out3, bus.out4, bus.out5, bus.out6, bus.out7, bus.out8};
  endfunction

  function automatic logic [63:0] pack8(input logic [7:0] v [8]);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = v[j];
    return r;
  endfunction

  // Expected frame: output j carries sample number bit-reverse(j).
  function automatic logic [63:0] reord(input logic [7:0] x [8]);
    logic [63:0] r;
    logic [2:0]  j3;
    for (int j = 0; j < 8; j++) begin
      j3 = 3'(j);
      r[63-8*j -: 8] = x[{j3[0], j3[1], j3[2]}];
    end
    return r;
  endfunction

  function automatic logic [63:0] reord_base(input logic [7:0] base);
    logic [7:0] x [8];
    for (int k = 0; k < 8; k++) x[k] = base + 8'(k);
    return reord(x);
  endfunction

  // Called at #1 after a clock edge; returns at #1 after the accepting edge.
  task automatic push(input logic [7:0] d, input bit track);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef FFT8_REORDER_SOF_EN
    bus.in_sof   = sof_drv;
`endif
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout: in_ready got 0 expected 1 (data %h)", d);
    end
    if (track) sb.push_back(d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
`ifdef FFT8_REORDER_SOF_EN
    bus.in_sof   = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef FFT8_REORDER_SOF_EN
    bus.in_sof = 1'b0; sof_drv = 1'b0;
`endif

    vecs[0].din  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    vecs[0].dout = '{8'h00, 8'h04, 8'h02, 8'h06, 8'h01, 8'h05, 8'h03, 8'h07};
    vecs[1].din  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    vecs[1].dout = '{8'h10, 8'h54, 8'h32, 8'h76, 8'h21, 8'h65, 8'h43, 8'h87};
    vecs[2].din  = '{8'hFF, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h81, 8'h00, 8'hC3};
    vecs[2].dout = '{8'hFF, 8'hFE, 8'h7F, 8'h00, 8'h80, 8'h81, 8'h01, 8'hC3};
    vecs[3].din  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h06, 8'h17};
    vecs[3].dout = '{8'hA0, 8'hE4, 8'hC2, 8'h06, 8'hB1, 8'hF5, 8'hD3, 8'h17};

    // Reset state
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_outs", outs(), 64'd0);
`ifdef FFT8_REORDER_SOF_EN
    chk("rst_sof_err", 64'(bus.sof_err), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Streaming vector table with out_ready held high
    bus.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("vec%0d_in_ready%0d", v, k), 64'(bus.in_ready), 64'd1);
        if (k > 0) chk($sformatf("vec%0d_no_early_valid%0d", v, k), 64'(bus.out_valid), 64'd0);
        push(vecs[v].din[k], 1'b0);
      end
      chk($sformatf("vec%0d_out_valid", v), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_outs", v), outs(), pack8(vecs[v].dout));
    end
    @(posedge clk); #1;
    chk("stream_valid_pulse", 64'(bus.out_valid), 64'd0);

    // Backpressure: two frames stored, third stalls
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0);
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_frame1", outs(), reord_base(8'h20));
    bus.in_valid = 1'b1; bus.in_data = 8'h30;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_frame1_hold", outs(), reord_base(8'h20));
    chk("bp_still_stalled", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_frame2", outs(), reord_base(8'h28));
    chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b0);
    chk("bp_stall_again", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_frame3", outs(), reord_base(8'h30));
    chk("bp_ready_after3", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Write completing B in the same cycle that A is read
    do_reset();
    for (int i = 0; i < 15; i++) push(8'h40 + 8'(i), 1'b0);
    bus.out_ready = 1'b1;
    push(8'h4F, 1'b0);
    bus.out_ready = 1'b0;
    chk("sc_out_valid", 64'(bus.out_valid), 64'd1);
    chk("sc_frameB", outs(), reord_base(8'h48));
    chk("sc_in_ready", 64'(bus.in_ready), 64'd1);
    push(8'h50, 1'b0);
    chk("sc_frameB_hold", outs(), reord_base(8'h48));
    bus.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) push(8'h50 + 8'(i), 1'b0);
    chk("sc_frameA", outs(), reord_base(8'h50));
    @(posedge clk); #1;

    // Reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_outs", outs(), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i), 1'b0);
    chk("mid_rst_frame0_valid", 64'(bus.out_valid), 64'd1);
    chk("mid_rst_frame0", outs(), reord_base(8'h00));
    @(posedge clk); #1;

`ifdef FFT8_REORDER_SOF_EN
    // SOF resync on the 4th sample, then an aligned SOF
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 1'b0);
    chk("sof_err_before", 64'(bus.sof_err), 64'd0);
    sof_drv = 1'b1; push(8'hB0, 1'b0); sof_drv = 1'b0;
    chk("sof_err_set", 64'(bus.sof_err), 64'd1);
    for (int i = 1; i < 8; i++) push(8'hB0 + 8'(i), 1'b0);
    chk("sof_frame_valid", 64'(bus.out_valid), 64'd1);
    chk("sof_frame", outs(), reord_base(8'hB0));
    sof_drv = 1'b1; push(8'hC0, 1'b0); sof_drv = 1'b0;
    for (int i = 1; i < 8; i++) push(8'hC0 + 8'(i), 1'b0);
    chk("sof_aligned_frame", outs(), reord_base(8'hC0));
    chk("sof_err_sticky", 64'(bus.sof_err), 64'd1);
    @(posedge clk); #1;
`endif

    // Random gaps on both sides, 100 frames through a scoreboard
    do_reset();
    sb.delete();
    fork
      begin
        for (int i = 0; i < 800; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
          push(8'($urandom), 1'b1);
        end
      end
      begin
        int frames, cyc;
        logic [7:0] x [8];
        frames = 0; cyc = 0;
        while (frames < 100 && cyc < 40000) begin
          @(posedge clk); #2;
          cyc++;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() < 8) begin
              checks++; failures++;
              $display("FAIL rnd_underflow: frame %0d queued %0d expected >=8", frames, sb.size());
            end else begin
              for (int k = 0; k < 8; k++) x[k] = sb.pop_front();
              chk($sformatf("rnd_frame%0d", frames), outs(), reord(x));
            end
            frames++;
          end
        end
        if (frames < 100) begin
          checks++; failures++;
          $display("FAIL rnd_timeout: frames got %0d expected 100", frames);
        end
      end
    join
    @(posedge clk); #2;
    bus.out_ready = 1'b0;
    chk("rnd_leftover", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
